// File: rtl/cpu_bus_arb_pkg.sv
// Shared types for the two-port external memory bus arbiter.
//   arb_state_e : sequencer states (IDLE -> ACCESS -> RECOVER -> IDLE)
//   PORT_CPU    : requester index of the cpu core
//   PORT_DMA    : requester index of the DMA / debug loader
package cpu_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the board-level
// memory/IO decoder.
//   requester side : i_reqN/i_weN/i_addrN/i_wdataN in, o_ackN/o_rdataN/o_errN out
//   memory side    : o_bus_clk/o_bus_we/o_bus_addr/o_bus_data out,
//                    i_bus_data/i_bus_data_ready in
//   status         : o_busy, o_owner
// modport master : the arbiter (it masters the external bus)
// modport slave  : the environment (requesters + memory decoder)
interface cpu_bus_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              i_req0;
    logic              i_we0;
    logic [ADDR_W-1:0] i_addr0;
    logic [DATA_W-1:0] i_wdata0;
    logic              o_ack0;
    logic [DATA_W-1:0] o_rdata0;
    logic              o_err0;

    logic              i_req1;
    logic              i_we1;
    logic [ADDR_W-1:0] i_addr1;
    logic [DATA_W-1:0] i_wdata1;
    logic              o_ack1;
    logic [DATA_W-1:0] o_rdata1;
    logic              o_err1;

    logic              o_bus_clk;
    logic              o_bus_we;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [DATA_W-1:0] o_bus_data;
    logic [DATA_W-1:0] i_bus_data;
    logic              i_bus_data_ready;

    logic              o_busy;
    logic              o_owner;

    modport master (
        input  i_req0, i_we0, i_addr0, i_wdata0,
        output o_ack0, o_rdata0, o_err0,
        input  i_req1, i_we1, i_addr1, i_wdata1,
        output o_ack1, o_rdata1, o_err1,
        output o_bus_clk, o_bus_we, o_bus_addr, o_bus_data,
        input  i_bus_data, i_bus_data_ready,
        output o_busy, o_owner
    );

    modport slave (
        output i_req0, i_we0, i_addr0, i_wdata0,
        input  o_ack0, o_rdata0, o_err0,
        output i_req1, i_we1, i_addr1, i_wdata1,
        input  o_ack1, o_rdata1, o_err1,
        input  o_bus_clk, o_bus_we, o_bus_addr, o_bus_data,
        output i_bus_data, i_bus_data_ready,
        input  o_busy, o_owner
    );

endinterface

// File: rtl/bus_rr_pick2.sv
// Combinational two-way round-robin pick.
//   i_req0, i_req1 : pending requests
//   i_last         : index of the last granted port
//   o_gnt_vld      : at least one request pending
//   o_gnt_idx      : winning port (a lone requester wins; on a tie the port
//                    that was not granted last wins)
module bus_rr_pick2
    import cpu_bus_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_gnt_vld,
    output logic o_gnt_idx
);

    always_comb begin
        o_gnt_vld = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_gnt_idx = ~i_last;
        end else if (i_req1) begin
            o_gnt_idx = PORT_DMA;
        end else begin
            o_gnt_idx = PORT_CPU;
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares the single external memory bus between the cpu core (port 0) and the
// DMA/debug loader (port 1). Each grant runs one single-word transfer through
// the strobe/ready handshake with an optional ready timeout.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : cpu_bus_arbiter_if.master (requester ports, memory bus,
//                  o_busy / o_owner status); every output is a flop.
module cpu_bus_arbiter
    import cpu_bus_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    cpu_bus_arbiter_if.master bus
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
    localparam bit              TO_EN  = (TIMEOUT != 0);

    arb_state_e             state_q, state_d;
    logic [TO_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                   owner_q, owner_d;
    logic                   bus_clk_q, bus_clk_d;
    logic                   bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]      bus_data_q, bus_data_d;
    logic [1:0]             ack_q, ack_d;
    logic [1:0]             err_q, err_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
    logic                   busy_q, busy_d;

    logic                   gnt_vld, gnt_idx;
    logic [1:0]             req_we;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;

    assign req_we    = {bus.i_we1, bus.i_we0};
    assign req_addr  = {bus.i_addr1, bus.i_addr0};
    assign req_wdata = {bus.i_wdata1, bus.i_wdata0};

    bus_rr_pick2 u_pick (
        .i_req0    (bus.i_req0),
        .i_req1    (bus.i_req1),
        .i_last    (owner_q),
        .o_gnt_vld (gnt_vld),
        .o_gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cnt_inc    = cnt_q + 1'b1;
        owner_d    = owner_q;
        bus_clk_d  = bus_clk_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        ack_d      = '0;        // ack/err are single-cycle pulses
        err_d      = '0;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                // A ready still high from the previous slave would complete
                // the new strobe instantly, so hold off until it drops.
                if (gnt_vld && !bus.i_bus_data_ready) begin
                    owner_d    = gnt_idx;
                    bus_clk_d  = 1'b1;
                    bus_we_d   = req_we[gnt_idx];
                    bus_addr_d = req_addr[gnt_idx];
                    bus_data_d = req_wdata[gnt_idx];
                    cnt_d      = '0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_inc;
                // Ready is tested first so it wins a same-cycle timeout.
                if (bus.i_bus_data_ready) begin
                    bus_clk_d        = 1'b0;
                    bus_we_d         = 1'b0;
                    ack_d[owner_q]   = 1'b1;
                    rdata_d[owner_q] = bus_we_q ? '0 : bus.i_bus_data;
                    state_d          = RECOVER;
                end else if (TO_EN && cnt_inc == TO_LIM) begin
                    // cnt_inc counts strobe-high cycles including this one
                    bus_clk_d        = 1'b0;
                    bus_we_d         = 1'b0;
                    ack_d[owner_q]   = 1'b1;
                    err_d[owner_q]   = 1'b1;
                    rdata_d[owner_q] = '0;
                    state_d          = RECOVER;
                end
            end
            RECOVER: begin
                cnt_d = '0;
                if (!bus.i_bus_data_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= PORT_DMA;     // so the cpu wins the first contest
            bus_clk_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            bus_clk_q  <= bus_clk_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_ack0      = ack_q[0];
    assign bus.o_err0      = err_q[0];
    assign bus.o_rdata0    = rdata_q[0];
    assign bus.o_ack1      = ack_q[1];
    assign bus.o_err1      = err_q[1];
    assign bus.o_rdata1    = rdata_q[1];
    assign bus.o_bus_clk   = bus_clk_q;
    assign bus.o_bus_we    = bus_we_q;
    assign bus.o_bus_addr  = bus_addr_q;
    assign bus.o_bus_data  = bus_data_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_owner     = owner_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: directed steps plus randomized rounds, checked
// against a transaction-level model of arbitration, memory contents, strobe
// length, timeout and recovery length.
module tb_cpu_bus_arbiter;
    import cpu_bus_arb_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TO  = 8;
    localparam int TOW = 8;

    logic i_clk;
    logic i_rst;

    cpu_bus_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();

    cpu_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO), .TO_W(TOW)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bif)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // requester intent
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    int          rem   [2];
    logic        raise [2];

    // memory responder
    int          lat;     // strobe-high observations before ready; -1 = never
    int          hold;    // observations ready stays high after strobe drops
    logic        rdy;
    logic [31:0] rdat;
    int          age, rel;
    logic [31:0] bus_mem   [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    // transaction model
    logic        last_own, active, cur_we, cur_tmo, prev_clk, in_rec, seen_xfer;
    int          cur_p, cur_len, hi_cnt, rec_cnt, exp_rec;
    logic [31:0] cur_addr, cur_wdata, last_addr, last_data;
    logic [31:0] exp_rd [2];
    int          grants [$];

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : mem_default(a);
    endfunction

    function automatic logic ack_of(input int p);
        return (p == 1) ? bif.o_ack1 : bif.o_ack0;
    endfunction

    function automatic logic err_of(input int p);
        return (p == 1) ? bif.o_err1 : bif.o_err0;
    endfunction

    function automatic logic [31:0] rdata_of(input int p);
        return (p == 1) ? bif.o_rdata1 : bif.o_rdata0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bif.i_req0           = req[0];
        bif.i_we0            = we[0];
        bif.i_addr0          = addr[0];
        bif.i_wdata0         = wdata[0];
        bif.i_req1           = req[1];
        bif.i_we1            = we[1];
        bif.i_addr1          = addr[1];
        bif.i_wdata1         = wdata[1];
        bif.i_bus_data_ready = rdy;
        bif.i_bus_data       = rdat;
    endtask

    task automatic clear_env();
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
            rem[p] = 0; raise[p] = 1'b0; exp_rd[p] = '0;
        end
        rdy = 1'b0; rdat = '0; age = 0; rel = 0; lat = 1; hold = 0;
        last_own = 1'b1; active = 1'b0; prev_clk = 1'b0; in_rec = 1'b0;
        seen_xfer = 1'b1; last_addr = '0; last_data = '0;   // reset bus value
        grants.delete();
    endtask

    task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        drive();
    endtask

    // One clock: advance, then check DUT outputs against the model and
    // update the responder and requesters for the next edge.
    task automatic tick();
        logic [1:0]  snap_req;
        logic        snap_rdy;
        logic [31:0] exp_r;
        snap_req = {req[1], req[0]};
        snap_rdy = rdy;
        @(posedge i_clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (raise[p]) begin req[p] = 1'b1; raise[p] = 1'b0; end
        end

        if (bif.o_bus_clk && !prev_clk) begin
            chk("start_ready_low", 64'(snap_rdy), 64'd0);
            chk("start_after_ack", 64'(active), 64'd0);
            chk("start_has_req", 64'(snap_req != 2'b00), 64'd1);
            if (snap_req == 2'b11) cur_p = last_own ? 0 : 1;
            else                   cur_p = snap_req[1] ? 1 : 0;
            last_own  = cur_p[0];
            active    = 1'b1;
            cur_we    = we[cur_p];
            cur_addr  = addr[cur_p];
            cur_wdata = wdata[cur_p];
            cur_tmo   = (lat < 0) || (lat > TO);
            cur_len   = cur_tmo ? TO : lat;
            hi_cnt    = 0;
            last_addr = cur_addr;
            last_data = cur_wdata;
            grants.push_back(cur_p);
        end
        if (bif.o_bus_clk) begin
            hi_cnt++;
            chk("busy_in_access", 64'(bif.o_busy), 64'd1);
            chk("bus_we", 64'(bif.o_bus_we), 64'(cur_we));
            chk("bus_addr", 64'(bif.o_bus_addr), 64'(cur_addr));
            chk("bus_data", 64'(bif.o_bus_data), 64'(cur_wdata));
        end

        if (!bif.o_bus_clk && prev_clk) begin
            chk("end_was_active", 64'(active), 64'd1);
            chk("strobe_len", 64'(hi_cnt), 64'(cur_len));
            chk("ack_owner", 64'(ack_of(cur_p)), 64'd1);
            chk("ack_other", 64'(ack_of(1 - cur_p)), 64'd0);
            chk("err", 64'(err_of(cur_p)), 64'(cur_tmo));
            if (!cur_tmo) chk("bus_we_cleared", 64'(bif.o_bus_we), 64'd0);
            exp_r = (cur_tmo || cur_we) ? 32'd0 : model_read(cur_addr);
            exp_rd[cur_p] = exp_r;
            if (cur_we && !cur_tmo) model_mem[cur_addr] = cur_wdata;
            active = 1'b0;
            req[cur_p] = 1'b0;
            if (rem[cur_p] > 0) begin rem[cur_p]--; raise[cur_p] = 1'b1; end
            in_rec  = 1'b1;
            rec_cnt = 0;
            exp_rec = cur_tmo ? 1 : hold + 1;
        end else begin
            chk("ack0_quiet", 64'(bif.o_ack0), 64'd0);
            chk("ack1_quiet", 64'(bif.o_ack1), 64'd0);
        end

        chk("rdata0", 64'(bif.o_rdata0), 64'(exp_rd[0]));
        chk("rdata1", 64'(bif.o_rdata1), 64'(exp_rd[1]));
        chk("owner", 64'(bif.o_owner), 64'(last_own));
        if (seen_xfer && !bif.o_bus_clk) begin
            chk("addr_hold", 64'(bif.o_bus_addr), 64'(last_addr));
            chk("data_hold", 64'(bif.o_bus_data), 64'(last_data));
        end
        if (in_rec) begin
            if (bif.o_busy) rec_cnt++;
            else begin
                chk("recover_len", 64'(rec_cnt), 64'(exp_rec));
                in_rec = 1'b0;
            end
        end
        if (!in_rec && !bif.o_bus_clk) chk("idle_not_busy", 64'(bif.o_busy), 64'd0);

        if (bif.o_bus_clk) begin
            age++; rel = 0;
            if (lat >= 0 && age == lat) begin
                rdy = 1'b1;
                if (bif.o_bus_we) bus_mem[bif.o_bus_addr] = bif.o_bus_data;
                else rdat = bus_mem.exists(bif.o_bus_addr) ? bus_mem[bif.o_bus_addr]
                                                           : mem_default(bif.o_bus_addr);
            end
        end else begin
            age = 0;
            if (rdy) begin
                rel++;
                if (rel > hold) rdy = 1'b0;
            end
        end
        prev_clk = bif.o_bus_clk;
        drive();
    endtask

    task automatic run_quiet(input string tag, input int budget);
        int n = 0;
        while ((req[0] || req[1] || raise[0] || raise[1] || active || in_rec || rdy)
               && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < budget), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bus_clk"}, 64'(bif.o_bus_clk), 64'd0);
        chk({tag, "_busy"},    64'(bif.o_busy),    64'd0);
        chk({tag, "_ack0"},    64'(bif.o_ack0),    64'd0);
        chk({tag, "_ack1"},    64'(bif.o_ack1),    64'd0);
        chk({tag, "_err0"},    64'(bif.o_err0),    64'd0);
        chk({tag, "_owner"},   64'(bif.o_owner),   64'd1);
        chk({tag, "_addr"},    64'(bif.o_bus_addr), 64'd0);
        chk({tag, "_rdata0"},  64'(bif.o_rdata0),  64'd0);
    endtask

    initial begin
        int k;
        clear_env();
        i_rst = 1'b1;
        drive();
        repeat (2) @(posedge i_clk);
        #1;
        check_reset_outputs("rst");
        #3 i_rst = 1'b0;

        // single read on port 0
        bus_mem[32'h1234]   = 32'hDEAD_BEEF;
        model_mem[32'h1234] = 32'hDEAD_BEEF;
        lat = 1; hold = 0;
        issue(0, 1'b0, 32'h1234, 32'h0);
        run_quiet("t1_done", 50);
        chk("t1_rdata", 64'(bif.o_rdata0), 64'hDEAD_BEEF);
        chk("t1_grant", 64'(grants[0]), 64'd0);

        // single write on port 1
        issue(1, 1'b1, 32'h0200, 32'h55);
        run_quiet("t2_done", 50);
        chk("t2_owner", 64'(bif.o_owner), 64'd1);
        chk("t2_mem", 64'(bus_mem[32'h0200]), 64'h55);

        // contention: four back-to-back grants must alternate
        grants.delete();
        rem[0] = 1; rem[1] = 1;
        issue(0, 1'b0, 32'h0200, 32'h0);
        issue(1, 1'b0, 32'h1234, 32'h0);
        run_quiet("t3_done", 100);
        chk("t3_count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk("t3_alternate", 64'(grants[i]), 64'(i % 2));

        // timeout, ready on the timeout cycle, one past it, then normal
        lat = -1;
        issue(0, 1'b0, 32'h0040, 32'h0);
        run_quiet("t4_tmo", 50);
        chk("t4_err", 64'(bif.o_rdata0), 64'd0);
        lat = TO;
        issue(0, 1'b0, 32'h0044, 32'h0);
        run_quiet("t4_edge", 50);
        lat = TO + 1;
        issue(1, 1'b1, 32'h0048, 32'h77);
        run_quiet("t4_late", 50);
        lat = 1;
        issue(0, 1'b0, 32'h0048, 32'h0);
        run_quiet("t4_after", 50);

        // slow ready release with the other port waiting
        hold = 3;
        issue(1, 1'b0, 32'h0200, 32'h0);
        issue(0, 1'b1, 32'h0300, 32'hA5);
        run_quiet("t5_done", 100);

        // stale ready while idle must hold off the strobe
        hold = 3; rdy = 1'b1; rel = 0;
        issue(0, 1'b0, 32'h0300, 32'h0);
        tick(); tick();
        chk("t6_stale_hold", 64'(bif.o_bus_clk), 64'd0);
        run_quiet("t6_done", 50);
        hold = 0;

        // asynchronous reset in the middle of an access
        lat = -1;
        issue(0, 1'b0, 32'h0050, 32'h0);
        k = 0;
        while (!bif.o_bus_clk && k < 6) begin tick(); k++; end
        chk("t7_strobe_up", 64'(bif.o_bus_clk), 64'd1);
        tick(); tick();
        #3 i_rst = 1'b1;
        #1;
        check_reset_outputs("t7_rst");
        clear_env();
        drive();
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        lat = 2;
        issue(1, 1'b0, 32'h0060, 32'h0);
        issue(0, 1'b0, 32'h0064, 32'h0);
        run_quiet("t7_done", 100);
        chk("t7_first_grant", 64'(grants[0]), 64'd0);

        // randomized rounds
        for (int r = 0; r < 30; r++) begin
            int mask, sel;
            mask = $urandom_range(1, 3);
            sel  = $urandom_range(0, 9);
            lat  = (sel == 0) ? -1 : (sel == 1) ? TO + 1 : (sel == 2) ? TO
                 : $urandom_range(1, 4);
            hold = $urandom_range(0, 2);
            for (int p = 0; p < 2; p++) begin
                if (mask[p])
                    issue(p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 2,
                          $urandom);
            end
            run_quiet("rand_done", 200);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
